// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_pkg
// Description : Shared BCD limits, edit-state encodings and BCD helper
//               functions for the RTC calendar slice.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    // BCD field limits
    localparam logic [7:0]  c_BCD_59   = 8'h59;
    localparam logic [7:0]  c_BCD_23   = 8'h23;
    localparam logic [7:0]  c_BCD_12   = 8'h12;
    localparam logic [7:0]  c_BCD_31   = 8'h31;
    localparam logic [7:0]  c_BCD_30   = 8'h30;
    localparam logic [7:0]  c_BCD_29   = 8'h29;
    localparam logic [7:0]  c_BCD_28   = 8'h28;
    localparam logic [15:0] c_BCD_9999 = 16'h9999;

    // Edit-stage state encodings; any TIME_EDIT_* state drives hold high
    localparam int unsigned c_EDIT_STATE_W = 3;
    localparam logic [c_EDIT_STATE_W-1:0] c_EDIT_IDLE        = 3'd0;
    localparam logic [c_EDIT_STATE_W-1:0] c_TIME_EDIT_YEAR   = 3'd1;
    localparam logic [c_EDIT_STATE_W-1:0] c_TIME_EDIT_MONTH  = 3'd2;
    localparam logic [c_EDIT_STATE_W-1:0] c_TIME_EDIT_DAY    = 3'd3;
    localparam logic [c_EDIT_STATE_W-1:0] c_TIME_EDIT_HOUR   = 3'd4;
    localparam logic [c_EDIT_STATE_W-1:0] c_TIME_EDIT_MINUTE = 3'd5;
    localparam logic [c_EDIT_STATE_W-1:0] c_TIME_EDIT_SECOND = 3'd6;

    // True for any state in which the edit stage owns the time fields
    function automatic logic is_time_edit(input logic [c_EDIT_STATE_W-1:0] state);
        return (state >= c_TIME_EDIT_YEAR) && (state <= c_TIME_EDIT_SECOND);
    endfunction

    // Both nibbles are decimal digits
    function automatic logic bcd_ok8(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // All four nibbles are decimal digits
    function automatic logic bcd_ok16(input logic [15:0] v);
        return bcd_ok8(v[15:8]) && bcd_ok8(v[7:0]);
    endfunction

    // Two-digit BCD increment (caller handles the field wrap)
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Four-digit ripple increment; 9999 naturally rolls to 0000
    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Two-digit BCD value divisible by 4, judged from the digits alone
    function automatic logic bcd_div4(input logic [3:0] tens, input logic [3:0] units);
        if (tens[0]) begin
            return (units == 4'd2) || (units == 4'd6);
        end
        return (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_calendar_if.sv
`default_nettype none
// ============================================================================
// Module      : rtc_calendar_if
// Description : Tick/hold/load controls and BCD time/date bus between the
//               edit stage (master) and the calendar register (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rtc_calendar_if;
    logic        tick_1hz;
    logic        hold;
    logic        load;
    logic [15:0] load_year;
    logic [7:0]  load_month;
    logic [7:0]  load_day;
    logic [7:0]  load_hour;
    logic [7:0]  load_minute;
    logic [7:0]  load_second;
    logic [15:0] year_bcd;
    logic [7:0]  month_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  hour_bcd;
    logic [7:0]  minute_bcd;
    logic [7:0]  second_bcd;
    logic        minute_pulse;
    logic        day_pulse;

    modport master (
        output tick_1hz, hold, load,
        output load_year, load_month, load_day, load_hour, load_minute, load_second,
        input  year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd,
        input  minute_pulse, day_pulse
    );

    modport slave (
        input  tick_1hz, hold, load,
        input  load_year, load_month, load_day, load_hour, load_minute, load_second,
        output year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd,
        output minute_pulse, day_pulse
    );
endinterface
`default_nettype wire

// File: rtl/rtc_days_in_month.sv
`default_nettype none
// ============================================================================
// Module      : rtc_days_in_month
// Description : Combinational BCD month length with Gregorian leap rule.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_days_in_month
    import rtc_pkg::*;
(
    input  wire logic [7:0]  i_month_bcd,
    input  wire logic [15:0] i_year_bcd,
    output logic      [7:0]  o_days_max
);

    logic w_low_div4;
    logic w_high_div4;
    logic w_leap;

    // Century years (low pair 00) are leap only when the high pair divides by 4
    assign w_low_div4  = bcd_div4(i_year_bcd[7:4],   i_year_bcd[3:0]);
    assign w_high_div4 = bcd_div4(i_year_bcd[15:12], i_year_bcd[11:8]);
    assign w_leap      = (i_year_bcd[7:0] == 8'h00) ? w_high_div4 : w_low_div4;

    // Month length lookup; unknown months fall back to 31
    always_comb begin
        o_days_max = c_BCD_31;
        case (i_month_bcd)
            8'h04, 8'h06, 8'h09, 8'h11: o_days_max = c_BCD_30;
            8'h02:                      o_days_max = w_leap ? c_BCD_29 : c_BCD_28;
            default:                    o_days_max = c_BCD_31;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module      : rtc_calendar
// Description : Free-running BCD time-of-day and calendar register with
//               sanitised load, hold and single-cycle ripple carry.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_calendar
    import rtc_pkg::*;
#(
    parameter logic [15:0] RESET_YEAR  = 16'h2024,
    parameter logic [7:0]  RESET_MONTH = 8'h01,
    parameter logic [7:0]  RESET_DAY   = 8'h01
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rtc_calendar_if.slave bus
);

    logic [15:0] r_year;
    logic [7:0]  r_month, r_day, r_hour, r_minute, r_second;
    logic        r_minute_pulse, r_day_pulse;

    logic [7:0]  w_cur_days_max, w_ld_days_max;
    logic [15:0] w_ld_year;
    logic [7:0]  w_ld_month, w_ld_day_raw, w_ld_day, w_ld_hour, w_ld_minute, w_ld_second;
    logic        w_sec_wrap, w_min_wrap, w_hour_wrap, w_day_wrap, w_month_wrap;
    logic        w_carry_min, w_carry_hour, w_carry_day, w_carry_month, w_carry_year;

    // Month length of the running date (tick path)
    rtc_days_in_month u_dim_cur (
        .i_month_bcd (r_month),
        .i_year_bcd  (r_year),
        .o_days_max  (w_cur_days_max)
    );

    // Month length of the sanitised load date (clamp path)
    rtc_days_in_month u_dim_load (
        .i_month_bcd (w_ld_month),
        .i_year_bcd  (w_ld_year),
        .o_days_max  (w_ld_days_max)
    );

    // Bad digits or out-of-range values collapse to the field minimum
    assign w_ld_year    = bcd_ok16(bus.load_year) ? bus.load_year : 16'h0000;
    assign w_ld_month   = (bcd_ok8(bus.load_month) && bus.load_month >= 8'h01 &&
                           bus.load_month <= c_BCD_12) ? bus.load_month : 8'h01;
    assign w_ld_day_raw = (bcd_ok8(bus.load_day) && bus.load_day >= 8'h01 &&
                           bus.load_day <= c_BCD_31) ? bus.load_day : 8'h01;
    assign w_ld_day     = (w_ld_day_raw > w_ld_days_max) ? w_ld_days_max : w_ld_day_raw;
    assign w_ld_hour    = (bcd_ok8(bus.load_hour) && bus.load_hour <= c_BCD_23) ?
                          bus.load_hour : 8'h00;
    assign w_ld_minute  = (bcd_ok8(bus.load_minute) && bus.load_minute <= c_BCD_59) ?
                          bus.load_minute : 8'h00;
    assign w_ld_second  = (bcd_ok8(bus.load_second) && bus.load_second <= c_BCD_59) ?
                          bus.load_second : 8'h00;

    // Whole carry chain resolves combinationally so every field moves on one edge
    assign w_sec_wrap    = (r_second == c_BCD_59);
    assign w_min_wrap    = (r_minute == c_BCD_59);
    assign w_hour_wrap   = (r_hour   == c_BCD_23);
    assign w_day_wrap    = (r_day    == w_cur_days_max);
    assign w_month_wrap  = (r_month  == c_BCD_12);
    assign w_carry_min   = w_sec_wrap;
    assign w_carry_hour  = w_carry_min   & w_min_wrap;
    assign w_carry_day   = w_carry_hour  & w_hour_wrap;
    assign w_carry_month = w_carry_day   & w_day_wrap;
    assign w_carry_year  = w_carry_month & w_month_wrap;

    // Calendar state: rst > load > hold > tick
    always_ff @(posedge clk) begin
        r_minute_pulse <= 1'b0;
        r_day_pulse    <= 1'b0;
        if (rst) begin
            r_year   <= RESET_YEAR;
            r_month  <= RESET_MONTH;
            r_day    <= RESET_DAY;
            r_hour   <= 8'h00;
            r_minute <= 8'h00;
            r_second <= 8'h00;
        end else if (bus.load) begin
            r_year   <= w_ld_year;
            r_month  <= w_ld_month;
            r_day    <= w_ld_day;
            r_hour   <= w_ld_hour;
            r_minute <= w_ld_minute;
            r_second <= w_ld_second;
        end else if (!bus.hold && bus.tick_1hz) begin
            r_second       <= w_sec_wrap ? 8'h00 : bcd_inc8(r_second);
            r_minute_pulse <= w_carry_min;
            r_day_pulse    <= w_carry_day;
            if (w_carry_min) begin
                r_minute <= w_min_wrap ? 8'h00 : bcd_inc8(r_minute);
            end
            if (w_carry_hour) begin
                r_hour <= w_hour_wrap ? 8'h00 : bcd_inc8(r_hour);
            end
            if (w_carry_day) begin
                r_day <= w_day_wrap ? 8'h01 : bcd_inc8(r_day);
            end
            if (w_carry_month) begin
                r_month <= w_month_wrap ? 8'h01 : bcd_inc8(r_month);
            end
            if (w_carry_year) begin
                r_year <= (r_year == c_BCD_9999) ? 16'h0000 : bcd_inc16(r_year);
            end
        end
    end

    assign bus.year_bcd     = r_year;
    assign bus.month_bcd    = r_month;
    assign bus.day_bcd      = r_day;
    assign bus.hour_bcd     = r_hour;
    assign bus.minute_bcd   = r_minute;
    assign bus.second_bcd   = r_second;
    assign bus.minute_pulse = r_minute_pulse;
    assign bus.day_pulse    = r_day_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rtc_calendar.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_calendar
// Description : Directed self-checking bench for rtc_calendar.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_calendar;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rtc_calendar_if bus ();

    rtc_calendar #(
        .RESET_YEAR  (16'h2024),
        .RESET_MONTH (8'h01),
        .RESET_DAY   (8'h01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full date/time as one packed word: YYYY MM DD hh mm ss
    function automatic logic [55:0] dt();
        return {bus.year_bcd, bus.month_bcd, bus.day_bcd,
                bus.hour_bcd, bus.minute_bcd, bus.second_bcd};
    endfunction

    function automatic logic [1:0] pulses();
        return {bus.minute_pulse, bus.day_pulse};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                              input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        bus.load_year   = y;
        bus.load_month  = mo;
        bus.load_day    = d;
        bus.load_hour   = h;
        bus.load_minute = mi;
        bus.load_second = s;
    endtask

    task automatic do_load(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                           input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        set_fields(y, mo, d, h, mi, s);
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    task automatic do_tick();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
    endtask

    initial begin
        int          mp_count;
        logic [15:0] leap_year [4];
        logic [15:0] leap_exp  [4];

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.hold     = 1'b0;
        bus.load     = 1'b0;
        set_fields(16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset for two cycles
        step();
        step();
        rst = 1'b0;
        chk("reset_dt", 64'(dt()), 64'h0020_2401_0100_0000);
        chk("reset_pulses", 64'(pulses()), 64'h0);

        // 60 ticks, one every other cycle
        mp_count = 0;
        for (int i = 0; i < 60; i++) begin
            do_tick();
            mp_count += int'(bus.minute_pulse);
            step();
            mp_count += int'(bus.minute_pulse);
        end
        chk("sixty_ticks_dt", 64'(dt()), 64'h0020_2401_0100_0100);
        chk("sixty_ticks_minute_pulses", 64'(mp_count), 64'd1);

        // Full rollover
        do_load(16'h2024, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
        chk("load_dt", 64'(dt()), 64'h0020_2412_3123_5959);
        chk("load_pulses", 64'(pulses()), 64'h0);
        do_tick();
        chk("rollover_dt", 64'(dt()), 64'h0020_2501_0100_0000);
        chk("rollover_pulses", 64'(pulses()), 64'h3);
        step();
        chk("pulses_one_cycle", 64'(pulses()), 64'h0);

        // February end across leap/non-leap/century years: expected MMDD after tick
        leap_year = '{16'h2024, 16'h2023, 16'h2000, 16'h2100};
        leap_exp  = '{16'h0229, 16'h0301, 16'h0229, 16'h0301};
        for (int i = 0; i < 4; i++) begin
            do_load(leap_year[i], 8'h02, 8'h28, 8'h23, 8'h59, 8'h59);
            do_tick();
            chk($sformatf("feb_end_%h", leap_year[i]), 64'(dt()),
                64'({leap_year[i], leap_exp[i], 24'h000000}));
        end

        // 30-day month end
        do_load(16'h2024, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59);
        do_tick();
        chk("apr30_rollover", 64'(dt()), 64'h0020_2405_0100_0000);

        // Load sanitising
        do_load(16'h2023, 8'h02, 8'h31, 8'h25, 8'h7A, 8'h30);
        chk("sanitise_feb31", 64'(dt()), 64'h0020_2302_2800_0030);
        do_load(16'h2024, 8'h04, 8'h31, 8'h12, 8'h34, 8'h56);
        chk("sanitise_apr31", 64'(dt()), 64'h0020_2404_3012_3456);
        do_load(16'h20A4, 8'h13, 8'h00, 8'h23, 8'h59, 8'h60);
        chk("sanitise_year_month_day", 64'(dt()), 64'h0000_0001_0123_5900);

        // Hold discards ticks with no catch-up
        do_load(16'h2024, 8'h06, 8'h15, 8'h10, 8'h20, 8'h30);
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_tick();
        end
        chk("hold_dt", 64'(dt()), 64'h0020_2406_1510_2030);
        chk("hold_pulses", 64'(pulses()), 64'h0);
        bus.hold = 1'b0;
        do_tick();
        chk("after_hold_dt", 64'(dt()), 64'h0020_2406_1510_2031);

        // Load beats a coincident tick
        set_fields(16'h2024, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
        bus.load     = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        bus.load     = 1'b0;
        bus.tick_1hz = 1'b0;
        chk("load_tick_dt", 64'(dt()), 64'h0020_2412_3123_5959);
        chk("load_tick_pulses", 64'(pulses()), 64'h0);

        // Load beats hold
        bus.hold = 1'b1;
        do_load(16'h1999, 8'h07, 8'h04, 8'h08, 8'h09, 8'h10);
        bus.hold = 1'b0;
        chk("load_over_hold", 64'(dt()), 64'h0019_9907_0408_0910);

        // Reset beats load
        set_fields(16'h2050, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05);
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.tick_1hz = 1'b1;
        step();
        rst          = 1'b0;
        bus.load     = 1'b0;
        bus.tick_1hz = 1'b0;
        chk("rst_over_load_dt", 64'(dt()), 64'h0020_2401_0100_0000);
        chk("rst_over_load_pulses", 64'(pulses()), 64'h0);

        // Year wrap
        do_load(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59);
        do_tick();
        chk("year_wrap_dt", 64'(dt()), 64'h0000_0001_0100_0000);
        chk("year_wrap_pulses", 64'(pulses()), 64'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
